// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divider control/finish stage: FSM states,
// iteration count and the ALU opcodes used for quotient negation.
package div_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int unsigned DIV_ITER = 32;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001
    } alu_op_t;

endpackage

// File: rtl/div_sequencer_alu.sv
// Minimal add/subtract ALU; the sequencer uses SUB with A=0 to negate the
// unsigned quotient magnitude.
module div_sequencer_alu
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  alu_op_t          i_op,
    output logic [WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/div_sequencer.sv
// Control/finish stage for the iterative restoring divider: starts the
// datapath, counts iterations, sign-corrects the quotient and flags exceptions.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = DIV_ITER
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               ctrl_DIV,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [2*WIDTH-1:0] currentAQ,
    output logic               div_load,
    output logic               busy,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_exception,
    output logic               data_resultRDY
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [5:0]         r_count;
    logic [5:0]         w_count_nxt;
    logic               r_negq;
    logic               w_negq_nxt;
    logic               r_dz;
    logic               w_dz_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               r_exc;
    logic               w_exc_nxt;
    logic               r_rdy;
    logic               w_rdy_nxt;

    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_q_neg;
    logic [WIDTH-1:0]   w_res;
    logic               w_a_min;
    logic               w_unused_aq_hi;

    // Datapath and FSM both act on the same start edge.
    assign div_load       = ctrl_DIV;
    assign busy           = (r_state == RUN) || (r_state == FIX);
    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

    assign w_q            = currentAQ[WIDTH-1:0];
    assign w_unused_aq_hi = ^currentAQ[2*WIDTH-1:WIDTH];
    assign w_a_min        = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}});

    div_sequencer_alu #(
        .WIDTH (WIDTH)
    ) u_neg (
        .i_a      ('0),
        .i_b      (w_q),
        .i_op     (ALU_SUB),
        .o_result (w_q_neg)
    );

    assign w_res = r_negq ? w_q_neg : w_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_negq_nxt   = r_negq;
        w_dz_nxt     = r_dz;
        w_ovf_nxt    = r_ovf;
        w_result_nxt = r_result;
        w_exc_nxt    = r_exc;
        w_rdy_nxt    = 1'b0;

        // A start pulse aborts any op in flight and restarts from scratch.
        if (ctrl_DIV) begin
            w_negq_nxt  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            w_dz_nxt    = (data_operandB == '0);
            w_ovf_nxt   = w_a_min && (data_operandB == '1);
            w_count_nxt = '0;
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                IDLE: ;
                RUN: begin
                    w_count_nxt = r_count + 6'd1;
                    if (r_count == 6'(ITER - 1))
                        w_state_nxt = FIX;
                end
                FIX: begin
                    w_result_nxt = (r_dz | r_ovf) ? '0 : w_res;
                    w_exc_nxt    = r_dz | r_ovf;
                    w_rdy_nxt    = 1'b1;
                    w_state_nxt  = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_negq   <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_negq   <= w_negq_nxt;
            r_dz     <= w_dz_nxt;
            r_ovf    <= w_ovf_nxt;
            r_result <= w_result_nxt;
            r_exc    <= w_exc_nxt;
            r_rdy    <= w_rdy_nxt;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: table of directed divides plus
// hand-written abort, back-to-back and mid-op reset sequences.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [63:0] currentAQ;
    logic        div_load;
    logic        busy;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] aq;
        logic [31:0] exp_res;
        logic        exp_exc;
    } vec_t;

    vec_t vecs [10];

    div_sequencer #(
        .WIDTH (32),
        .ITER  (32)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .currentAQ      (currentAQ),
        .div_load       (div_load),
        .busy           (busy),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive a start for one cycle; returns one cycle later (cycle 1 of the op).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] aq);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        currentAQ     = {32'h0, aq};
        tick();
        ctrl_DIV = 1'b0;
    endtask

    // Observe n cycles, counting RDY pulses and cycles where busy is low.
    task automatic watch(input int n, output int rdy_seen, output int idle_seen);
        rdy_seen  = 0;
        idle_seen = 0;
        for (int c = 0; c < n; c++) begin
            if (data_resultRDY !== 1'b0) rdy_seen++;
            if (busy !== 1'b1) idle_seen++;
            tick();
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rdy_seen;
        int idle_seen;
        ctrl_DIV      = 1'b1;
        data_operandA = v.a;
        data_operandB = v.b;
        currentAQ     = {32'h0, v.aq};
        #1;
        check({tag, " div_load"}, 32'(div_load), 32'd1);
        tick();
        ctrl_DIV = 1'b0;
        watch(33, rdy_seen, idle_seen);
        check({tag, " early_rdy"}, rdy_seen, 0);
        check({tag, " busy_run"}, idle_seen, 0);
        check({tag, " rdy34"}, 32'(data_resultRDY), 32'd1);
        check({tag, " result"}, data_result, v.exp_res);
        check({tag, " exc"}, 32'(data_exception), 32'(v.exp_exc));
        check({tag, " busy34"}, 32'(busy), 32'd0);
        tick();
        check({tag, " rdy35"}, 32'(data_resultRDY), 32'd0);
        check({tag, " hold35"}, data_result, v.exp_res);
    endtask

    initial begin
        int rdy_seen;
        int idle_seen;

        vecs[0] = '{32'd7,          32'd2,          32'd3,          32'd3,          1'b0};
        vecs[1] = '{32'hFFFF_FFF9, 32'd2,          32'd3,          32'hFFFF_FFFD, 1'b0};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,          32'd3,          1'b0};
        vecs[4] = '{32'd5,          32'd0,          32'hFFFF_FFFF, 32'd0,          1'b1};
        vecs[5] = '{32'd9,          32'd3,          32'd3,          32'd3,          1'b0};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          1'b1};
        vecs[7] = '{32'h8000_0000, 32'd1,          32'h8000_0000, 32'h8000_0000, 1'b0};
        vecs[8] = '{32'd100,        32'd7,          32'd14,         32'd14,         1'b0};
        vecs[9] = '{32'hFFFF_FF9C, 32'd7,          32'd14,         32'hFFFF_FFF2, 1'b0};

        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        currentAQ     = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset result", data_result, 32'd0);
        check("reset exc", 32'(data_exception), 32'd0);
        check("reset rdy", 32'(data_resultRDY), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort: 100/7 restarted at cycle 10 by 50/5; single RDY at cycle 44.
        start_op(32'd100, 32'd7, 32'd14);
        watch(9, rdy_seen, idle_seen);
        start_op(32'd50, 32'd5, 32'd10);
        watch(33, rdy_seen, idle_seen);
        check("abort early_rdy", rdy_seen, 0);
        check("abort busy", idle_seen, 0);
        check("abort rdy44", 32'(data_resultRDY), 32'd1);
        check("abort result", data_result, 32'd10);
        check("abort exc", 32'(data_exception), 32'd0);
        tick();
        check("abort rdy45", 32'(data_resultRDY), 32'd0);

        // Back-to-back: new start in the RDY cycle of the previous op.
        start_op(32'd9, 32'd3, 32'd3);
        watch(33, rdy_seen, idle_seen);
        check("b2b rdy34", 32'(data_resultRDY), 32'd1);
        check("b2b result1", data_result, 32'd3);
        start_op(32'd7, 32'hFFFF_FFFE, 32'd3);
        check("b2b rdy_clear", 32'(data_resultRDY), 32'd0);
        check("b2b hold", data_result, 32'd3);
        check("b2b busy", 32'(busy), 32'd1);
        watch(33, rdy_seen, idle_seen);
        check("b2b early_rdy2", rdy_seen, 0);
        check("b2b rdy2", 32'(data_resultRDY), 32'd1);
        check("b2b result2", data_result, 32'hFFFF_FFFD);

        // Reset mid-op at cycle 20 of 100/7.
        tick();
        start_op(32'd100, 32'd7, 32'd14);
        watch(19, rdy_seen, idle_seen);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst result", data_result, 32'd0);
        check("rst exc", 32'(data_exception), 32'd0);
        check("rst rdy", 32'(data_resultRDY), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        rdy_seen = 0;
        idle_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (data_resultRDY !== 1'b0) rdy_seen++;
            if (busy !== 1'b0) idle_seen++;
            tick();
        end
        check("rst no_rdy", rdy_seen, 0);
        check("rst no_busy", idle_seen, 0);
        run_vec(vecs[5], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
